// File: rtl/rx_iq_fifo_pkg.sv
// Shared constants for the receive I/Q sample FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rx_iq_fifo_pkg;

  // Default width of one I or Q sample.
  localparam int DATA_W_DFLT = 24;

  // Default FIFO depth in I/Q pairs (must be a power of two, >= 2).
  localparam int DEPTH_DFLT = 8;

  // Pointer width for the default depth.
  localparam int PTR_W_DFLT = $clog2(DEPTH_DFLT);

endpackage

// File: rtl/iq_fifo_mem.sv
// Storage array for I/Q pairs: DEPTH x WIDTH, synchronous write, combinational read.
// Latency: write lands on the clk edge; read data follows rd_addr in the same cycle.
// Backpressure: none; the caller guarantees it never writes into a live entry.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr/rd_dat read port.
module iq_fifo_mem
  import rx_iq_fifo_pkg::*;
#(
  parameter int WIDTH  = 2 * DATA_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  // No reset: an empty FIFO never exposes these entries.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/rx_iq_fifo.sv
// Receive-side I/Q pair FIFO between the decimating receiver and the I2S output.
// Latency: 1 cycle from out_req to out_valid with registered out_real/out_imag.
// Backpressure: none upstream; writes to a full FIFO are dropped and flagged (overflow),
//               reads of an empty FIFO are ignored and flagged (underflow).
// Ports: clk/reset; in_valid/in_real/in_imag write strobe; out_req read strobe;
//        out_valid/out_real/out_imag read result; fill_level; sticky overflow/underflow
//        with synchronous clr_flags.
module rx_iq_fifo
  import rx_iq_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_real,
  input  logic [DATA_W-1:0]        in_imag,
  input  logic                     out_req,
  output logic [DATA_W-1:0]        out_real,
  output logic [DATA_W-1:0]        out_imag,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   out_real_q, out_real_d;
  logic [DATA_W-1:0]   out_imag_q, out_imag_d;
  logic                out_valid_q, out_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                full, empty, wr_en, rd_en;
  logic [2*DATA_W-1:0] rd_dat;

  iq_fifo_mem #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_dat ({in_real, in_imag}),
    .rd_addr(rd_ptr_q),
    .rd_dat (rd_dat)
  );

  always_comb begin
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);

    rd_en = out_req & ~empty;
    // When full, a same-cycle read frees the head slot. Write and read share the
    // same address then, and the read samples the old contents before the edge.
    // An empty FIFO is still written; there is no bypass to the outputs.
    wr_en = in_valid & (~full | rd_en);

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    out_valid_d = rd_en;
    out_real_d  = rd_en ? rd_dat[2*DATA_W-1:DATA_W] : out_real_q;
    out_imag_d  = rd_en ? rd_dat[DATA_W-1:0]        : out_imag_q;

    // A set condition in the same cycle as clr_flags wins.
    overflow_d  = (in_valid & full & ~rd_en) | (overflow_q  & ~clr_flags);
    underflow_d = (out_req & empty)          | (underflow_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign out_valid  = out_valid_q;
  assign fill_level = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Bench for rx_iq_fifo: queue-based reference model plus an output scoreboard.
// Latency: expects out_valid exactly one cycle after each serviced out_req.
// Backpressure: models drop-on-full and ignore-on-empty with sticky flags.
module tb_rx_iq_fifo;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_real = '0;
  logic [DATA_W-1:0] in_imag = '0;
  logic              out_req = 1'b0;
  logic              clr_flags = 1'b0;
  logic [DATA_W-1:0] out_real, out_imag;
  logic              out_valid;
  logic [LVL_W-1:0]  fill_level;
  logic              overflow, underflow;

  rx_iq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_req   (out_req),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_valid (out_valid),
    .fill_level(fill_level),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*DATA_W-1:0] d;
    int                  c;
  } exp_t;

  exp_t                expq[$];   // expected reads with the cycle they must appear in
  logic [2*DATA_W-1:0] mq[$];     // reference FIFO contents
  logic                m_ovf = 1'b0;
  logic                m_unf = 1'b0;
  logic [2*DATA_W-1:0] last_out = '0;
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model decides what the DUT must do on this edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                      input logic req, input logic clr);
    bit full, empty, rd;
    in_valid  = iv;
    in_real   = re;
    in_imag   = im;
    out_req   = req;
    clr_flags = clr;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    rd    = req && !empty;
    if (rd) begin
      last_out = mq.pop_front();
      expq.push_back('{d: last_out, c: cyc + 1});
    end
    if (iv && (!full || rd)) mq.push_back({re, im});
    m_ovf = (iv && full && !rd) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (req && empty)      ? 1'b1 : (clr ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_req   = 1'b0;
    clr_flags = 1'b0;
    @(negedge clk);
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
    if (!rd) begin
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("hold_data", 64'({out_real, out_imag}), 64'(last_out));
    end
  endtask

  task automatic wr(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
    step(1'b1, re, im, 1'b0, 1'b0);
  endtask

  task automatic rd_req();
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every out_valid pops one expected pair and must land on its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].c < cyc) begin
        checks++;
        errors++;
        $display("FAIL read_latency: no out_valid at cycle %0d, expected pair %0h", expq[0].c, expq[0].d);
        void'(expq.pop_front());
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got pair %0h at cycle %0d, expected none", {out_real, out_imag}, cyc);
        end else begin
          e = expq.pop_front();
          if (e.c != cyc || {out_real, out_imag} !== e.d) begin
            errors++;
            $display("FAIL read_data: got %0h at cycle %0d, expected %0h at cycle %0d",
                     {out_real, out_imag}, cyc, e.d, e.c);
          end
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] r, q;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_fill_level", 64'(fill_level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'({out_real, out_imag}), 64'd0);
    chk("rst_flags", 64'({overflow, underflow}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three fixed pairs in, three out in order; level 3 -> 0.
    wr(24'h000001, 24'hFFFFFF);
    wr(24'h7FFFFF, 24'h800000);
    wr(24'h123456, 24'h654321);
    repeat (3) rd_req();

    // Nine writes into a depth-8 FIFO: ninth dropped, overflow set; then drain.
    for (int i = 0; i < 9; i++) wr(24'($urandom), 24'($urandom));
    for (int i = 0; i < 8; i++) rd_req();
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Full FIFO with simultaneous write and read: level stays 8, no overflow.
    for (int i = 0; i < 8; i++) wr(24'($urandom), 24'($urandom));
    step(1'b1, 24'hABCDEF, 24'h0F0F0F, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd_req();

    // Empty FIFO read: underflow, outputs hold; set beats clear; then clear.
    rd_req();
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    // Empty with simultaneous write and request: written, not read out.
    step(1'b1, 24'h111111, 24'h222222, 1'b1, 1'b0);
    rd_req();
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Twenty interleaved write/read pairs: pointers wrap, level stays <= 1.
    for (int i = 0; i < 20; i++) begin
      wr(24'($urandom), 24'($urandom));
      if (i % 4 == 3) step(1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b0);
      rd_req();
      if (i % 4 == 3) rd_req();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = 24'($urandom);
      q = 24'($urandom);
      step(1'($urandom_range(0, 1)), r, q, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    while (mq.size() > 0) rd_req();
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset mid-operation with 5 pairs stored, nonzero outputs and overflow set.
    for (int i = 0; i < 9; i++) wr(24'($urandom) | 24'h1, 24'($urandom));
    repeat (3) rd_req();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_fill_level", 64'(fill_level), 64'd0);
    chk("arst_out_data", 64'({out_real, out_imag}), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_underflow", 64'(underflow), 64'd0);
    mq.delete();
    last_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    rd_req();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_iq_fifo.md
RX_IQ_FIFO -- requirements
Module: rx_iq_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 24, the width of each I or Q sample.
REQ-002 SHALL have parameter DEPTH, default 8, the FIFO depth in I/Q pairs; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, width 1; it is the only clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, width 1; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, width 1; a one-cycle strobe from the Receiver marking a new decimated I/Q pair.
REQ-006 SHALL have port in_real, input, width DATA_W; the I sample, signed two's complement.
REQ-007 SHALL have port in_imag, input, width DATA_W; the Q sample, signed two's complement.
REQ-008 SHALL have port out_req, input, width 1; a one-cycle strobe from the I2S side requesting the next pair.
REQ-009 SHALL have port out_real, output, width DATA_W; the registered I sample toward I2S.
REQ-010 SHALL have port out_imag, output, width DATA_W; the registered Q sample toward I2S.
REQ-011 SHALL have port out_valid, output, width 1; a one-cycle strobe meaning out_real/out_imag were updated.
REQ-012 SHALL have port fill_level, output, width log2(DEPTH)+1; the number of stored pairs.
REQ-013 SHALL have port overflow, output, width 1; sticky flag, set when an input pair is dropped.
REQ-014 SHALL have port underflow, output, width 1; sticky flag, set when a request finds the FIFO empty.
REQ-015 SHALL have port clr_flags, input, width 1; synchronous clear of overflow and underflow.

Function
REQ-016 Write: in_valid=1 and FIFO not full -> store {in_real,in_imag} at the write pointer; write pointer +1, wrapping modulo DEPTH.
REQ-017 Read: out_req=1 and FIFO not empty -> on the next clk edge, the head pair is loaded to out_real/out_imag, out_valid=1 for exactly one cycle, read pointer +1 with wrap.
REQ-018 Read latency SHALL be exactly 1 cycle from out_req to out_valid.
REQ-019 out_real/out_imag SHALL hold their last value while out_valid=0.
REQ-020 Full and in_valid, with no simultaneous read -> pair dropped, FIFO contents unchanged, overflow set on the next edge.
REQ-021 Full and in_valid and out_req in the same cycle -> both operations occur; fill_level is unchanged; overflow is not set.
REQ-022 Empty and out_req, in the same cycle or not -> no read; out_valid=0; outputs hold; underflow set; a simultaneous in_valid is still written (no bypass).
REQ-023 Simultaneous write and read, FIFO neither empty nor full -> both occur; fill_level is unchanged.
REQ-024 fill_level SHALL be exact, in the range 0..DEPTH, and registered.
REQ-025 clr_flags=1 clears both flags; a set condition in the same cycle SHALL win, leaving the flag 1.
REQ-026 No arithmetic is performed on sample data; it passes bit-exact.

Reset
REQ-027 reset SHALL asynchronously force: both pointers=0, fill_level=0, out_real=0, out_imag=0, out_valid=0, overflow=0, underflow=0.
REQ-028 Storage RAM contents need not be reset; an empty FIFO never exposes them.
REQ-029 Reset asserted mid-operation SHALL discard all stored pairs; the first request after release underflows.

Structure
REQ-030 A shared package SHALL hold the DATA_W and DEPTH defaults and the pointer-width constant, clog2(DEPTH).
REQ-031 One sub-module, iq_fifo_mem, SHALL be used: a simple dual-port register array of DEPTH x 2*DATA_W, with a synchronous write and a combinational read at the read address.
REQ-032 Pointer, level and flag logic SHALL reside in rx_iq_fifo.

Verification
REQ-033 The bench SHALL cover: reset, write 3 pairs (0x000001/0xFFFFFF, 0x7FFFFF/0x800000, 0x123456/0x654321), 3 out_req -> same pairs in order, each with out_valid one cycle after its out_req; fill_level 3->0.
REQ-034 The bench SHALL cover: 9 writes with no reads, DEPTH=8 -> fill_level=8, overflow=1, the 9th pair absent, 8 reads return pairs 1..8.
REQ-035 The bench SHALL cover: full FIFO with in_valid and out_req in the same cycle -> fill_level stays 8, overflow=0, the new pair is read out last.
REQ-036 The bench SHALL cover: empty FIFO and out_req -> out_valid=0, outputs hold the previous pair, underflow=1; then clr_flags -> underflow=0.
REQ-037 The bench SHALL cover: 20 write/read pairs interleaved -> pointers wrap, data stays bit-exact, fill_level never exceeds 1.
REQ-038 The bench SHALL cover: reset asserted with 5 pairs stored -> all outputs 0 immediately, without waiting for clk; after release, out_req -> underflow=1.
